spw_link_fsm: RTL and testbench
===============================

// Module: spw_link_fsm
// PURPOSE
//  SpaceWire link-interface state machine (ECSS-E-ST-50-12C, clause 8.5).
//  Sequences the character receiver and transmitter through
//  ErrorReset/ErrorWait/Ready/Started/Connecting/Run.
//  Consumes pclk-domain event pulses from the receiver and drives the receiver reset,
//  transmitter mode and link status.
//  RX event inputs are already synchronised into pclk upstream.
// PARAMETERS
//  TICKS_6U4   64   pclk cycles in 6.4 us (default = 10 MHz pclk)
//  TICKS_12U8  128  pclk cycles in 12.8 us; must be > TICKS_6U4
// PORTS
//  Clock and reset: one clock; reset is asynchronous and active-high.
//  pclk             in   1  system clock, rising edge
//  reset            in   1  async active-high reset
//  link_start       in   1  level: request link start
//  link_disable     in   1  level: force link down
//  auto_start       in   1  level: start on first received NULL
//  rx_got_null      in   1  1-cycle pulse: NULL received
//  rx_got_fct       in   1  1-cycle pulse: FCT received
//  rx_got_nchar     in   1  1-cycle pulse: N-Char received
//  rx_got_time_code in   1  1-cycle pulse: time-code received
//  rx_error         in   1  1-cycle pulse: parity/escape error
//  rx_disconnect    in   1  1-cycle pulse: disconnect timeout
//  credit_error     in   1  1-cycle pulse: credit overflow (from flow control)
//  rx_resetn_o      out  1  active-low reset to receiver
//  tx_mode          out  2  0=off, 1=NULL only, 2=NULL+FCT, 3=full (data/time)
//  link_up          out  1  high in Run
//  fsm_state        out  3  0 ErrRst, 1 ErrWait, 2 Ready, 3 Started, 4 Connecting, 5 Run
//  err_count        out  8  saturating count of entries into ErrRst from states 1-5
// BEHAVIOUR
//  Reset: state=ErrRst, rx_resetn_o=0, tx_mode=0, link_up=0, err_count=0,
//   timer=0, got_null_flag=0.
//  Outputs: registered, decoded from next_state; they change on the same edge as fsm_state.
//  Timer: cleared on every state change, otherwise +1 per cycle.
//   Width: $clog2(TICKS_12U8+1).
//   "T6 expires": timer==TICKS_6U4-1. "T12 expires": timer==TICKS_12U8-1.
//  got_null_flag: set by rx_got_null in any state except ErrRst; cleared in ErrRst.
//  link_enabled: !link_disable & (link_start | (auto_start & got_null_flag)).
//  fail: rx_error | rx_disconnect.
//  Transitions, evaluated in this priority order:
//   ErrRst   : rx_resetn_o=0, tx_mode=0. T6 expires -> ErrWait.
//              Inputs are ignored; state is held for exactly TICKS_6U4 cycles.
//   ErrWait  : rx_resetn_o=1, tx_mode=0.
//              fail|got_fct|got_nchar|got_time_code -> ErrRst.
//              Else T12 expires -> Ready.
//   Ready    : tx_mode=0. fail|fct|nchar|tc -> ErrRst. Else link_enabled -> Started.
//   Started  : tx_mode=1. fail|fct|nchar|tc -> ErrRst.
//              Else got_null_flag (incl. this-cycle rx_got_null) -> Connecting.
//              Else T12 expires -> ErrRst.
//   Connecting: tx_mode=2. fail|nchar|tc -> ErrRst. Else rx_got_fct -> Run.
//               Else T12 expires -> ErrRst.
//   Run      : tx_mode=3, link_up=1.
//              fail|credit_error|link_disable -> ErrRst; otherwise stay.
//  Simultaneous events: an error-class event always wins over an advance or timeout.
//  link_disable has no effect in ErrRst/ErrWait/Ready/Started/Connecting;
//   it only blocks link_enabled.
//  err_count: increments on every transition into ErrRst from a non-ErrRst state;
//   saturates at 255.
//  Async reset mid-operation: immediate return to reset values, including timer
//   and got_null_flag.
//  Illegal fsm_state values 6/7: next cycle ErrRst, with no err_count increment.
// TESTING
//  1 Release reset, no stimulus -> ErrWait at cycle 64, Ready at cycle 192;
//    rx_resetn_o=1 from cycle 64.
//  2 Ready, link_start=1 -> Started (tx_mode=1).
//    NULL pulse at +10 -> Connecting (tx_mode=2).
//    FCT at +20 -> Run, link_up=1.
//  3 Started with no NULL -> ErrRst after exactly 128 cycles; err_count=1.
//  4 auto_start=1, link_start=0, NULL arrives in ErrWait -> Started on the first Ready cycle.
//  5 Run with rx_error and rx_got_fct in the same cycle -> ErrRst;
//    tx_mode=0 and rx_resetn_o=0 on that edge.
//  6 Connecting, reset pulsed high for 1 cycle -> fsm_state=0, err_count=0;
//    full 64-cycle ErrRst hold follows.

Source files
------------

// File: rtl/spw_link_fsm_if.sv
// Link-interface signal bundle: controls and receiver event pulses going into the
// link FSM, and receiver reset / transmitter mode / status coming out of it.
interface spw_link_fsm_if;
    // Control levels
    logic       link_start;
    logic       link_disable;
    logic       auto_start;

    // Receiver and flow-control event pulses (already in the pclk domain)
    logic       rx_got_null;
    logic       rx_got_fct;
    logic       rx_got_nchar;
    logic       rx_got_time_code;
    logic       rx_error;
    logic       rx_disconnect;
    logic       credit_error;

    // FSM results
    logic       rx_resetn_o;
    logic [1:0] tx_mode;
    logic       link_up;
    logic [2:0] fsm_state;
    logic [7:0] err_count;

    // Side that drives controls/events and observes status
    modport master (
        output link_start, link_disable, auto_start,
        output rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code,
        output rx_error, rx_disconnect, credit_error,
        input  rx_resetn_o, tx_mode, link_up, fsm_state, err_count
    );

    // The link FSM itself
    modport slave (
        input  link_start, link_disable, auto_start,
        input  rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code,
        input  rx_error, rx_disconnect, credit_error,
        output rx_resetn_o, tx_mode, link_up, fsm_state, err_count
    );
endinterface

// File: rtl/spw_link_fsm.sv
// SpaceWire link-interface state machine.
// Walks ErrorReset -> ErrorWait -> Ready -> Started -> Connecting -> Run, dropping
// back to ErrorReset on any error-class event. All outputs are registered and are
// decoded from the next state, so they switch on the same edge as fsm_state.
// TICKS_12U8 must be larger than TICKS_6U4.
module spw_link_fsm #(
    parameter int TICKS_6U4  = 64,
    parameter int TICKS_12U8 = 128
) (
    input  logic           pclk,
    input  logic           reset,
    spw_link_fsm_if.slave  lnk
);

    localparam int TW = $clog2(TICKS_12U8 + 1);

    typedef enum logic [2:0] {
        ERR_RST    = 3'd0,
        ERR_WAIT   = 3'd1,
        READY      = 3'd2,
        STARTED    = 3'd3,
        CONNECTING = 3'd4,
        RUN        = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          got_null_q, got_null_d;
    logic          rx_resetn_q, rx_resetn_d;
    logic [1:0]    tx_mode_q, tx_mode_d;
    logic          link_up_q, link_up_d;
    logic [7:0]    err_count_q, err_count_d;

    logic t6_exp;
    logic t12_exp;
    logic fail;
    logic link_enabled;
    logic rx_class_err;

    assign t6_exp       = (timer_q == TW'(TICKS_6U4 - 1));
    assign t12_exp      = (timer_q == TW'(TICKS_12U8 - 1));
    assign fail         = lnk.rx_error | lnk.rx_disconnect;
    // Any character other than NULL is illegal before the link is running
    assign rx_class_err = fail | lnk.rx_got_fct | lnk.rx_got_nchar | lnk.rx_got_time_code;
    assign link_enabled = !lnk.link_disable &
                          (lnk.link_start | (lnk.auto_start & got_null_q));

    // Next-state selection; error-class events are tested before advances/timeouts
    always_comb begin
        state_d = state_q;
        case (state_q)
            ERR_RST: begin
                if (t6_exp) state_d = ERR_WAIT;
            end
            ERR_WAIT: begin
                if (rx_class_err)  state_d = ERR_RST;
                else if (t12_exp)  state_d = READY;
            end
            READY: begin
                if (rx_class_err)       state_d = ERR_RST;
                else if (link_enabled)  state_d = STARTED;
            end
            STARTED: begin
                if (rx_class_err)                          state_d = ERR_RST;
                else if (got_null_q | lnk.rx_got_null)     state_d = CONNECTING;
                else if (t12_exp)                          state_d = ERR_RST;
            end
            CONNECTING: begin
                if (fail | lnk.rx_got_nchar | lnk.rx_got_time_code) state_d = ERR_RST;
                else if (lnk.rx_got_fct)                            state_d = RUN;
                else if (t12_exp)                                   state_d = ERR_RST;
            end
            RUN: begin
                if (fail | lnk.credit_error | lnk.link_disable) state_d = ERR_RST;
            end
            default: state_d = ERR_RST;
        endcase
    end

    // Timer, NULL-seen flag and error counter updates
    always_comb begin
        timer_d     = (state_d != state_q) ? '0 : timer_q + 1'b1;
        got_null_d  = (state_q == ERR_RST) ? 1'b0 : (got_null_q | lnk.rx_got_null);
        err_count_d = err_count_q;
        // Only real error entries count; recovery from a corrupt state code does not
        if ((state_d == ERR_RST) && (state_q inside {ERR_WAIT, READY, STARTED, CONNECTING, RUN})
            && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Output decode from the next state so outputs track fsm_state edge-for-edge
    always_comb begin
        rx_resetn_d = 1'b1;
        tx_mode_d   = 2'd0;
        link_up_d   = 1'b0;
        case (state_d)
            ERR_RST:    rx_resetn_d = 1'b0;
            STARTED:    tx_mode_d   = 2'd1;
            CONNECTING: tx_mode_d   = 2'd2;
            RUN: begin
                tx_mode_d = 2'd3;
                link_up_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q     <= ERR_RST;
            timer_q     <= '0;
            got_null_q  <= 1'b0;
            rx_resetn_q <= 1'b0;
            tx_mode_q   <= 2'd0;
            link_up_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            got_null_q  <= got_null_d;
            rx_resetn_q <= rx_resetn_d;
            tx_mode_q   <= tx_mode_d;
            link_up_q   <= link_up_d;
            err_count_q <= err_count_d;
        end
    end

    assign lnk.rx_resetn_o = rx_resetn_q;
    assign lnk.tx_mode     = tx_mode_q;
    assign lnk.link_up     = link_up_q;
    assign lnk.fsm_state   = state_q;
    assign lnk.err_count   = err_count_q;

endmodule

// File: tb/tb_spw_link_fsm.sv
// Directed bench for the SpaceWire link FSM: walks the state sequence, timeouts,
// error priority, auto-start, link_disable and an asynchronous reset mid-link.
module tb_spw_link_fsm;

    logic pclk;
    logic reset;
    int   n_asserts;
    int   n_fail;

    spw_link_fsm_if lnk ();

    spw_link_fsm #(
        .TICKS_6U4  (64),
        .TICKS_12U8 (128)
    ) dut (
        .pclk  (pclk),
        .reset (reset),
        .lnk   (lnk)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int rxr, input int txm,
                           input int lup, input int errc);
        chk({tag, ".state"},     32'(lnk.fsm_state),   32'(st));
        chk({tag, ".rx_resetn"}, 32'(lnk.rx_resetn_o), 32'(rxr));
        chk({tag, ".tx_mode"},   32'(lnk.tx_mode),     32'(txm));
        chk({tag, ".link_up"},   32'(lnk.link_up),     32'(lup));
        chk({tag, ".err_count"}, 32'(lnk.err_count),   32'(errc));
        $display("step %-14s state=%0d rx_resetn=%0d tx_mode=%0d link_up=%0d err=%0d",
                 tag, lnk.fsm_state, lnk.rx_resetn_o, lnk.tx_mode, lnk.link_up, lnk.err_count);
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b1;
        lnk.link_start = 0; lnk.link_disable = 0; lnk.auto_start = 0;
        lnk.rx_got_null = 0; lnk.rx_got_fct = 0; lnk.rx_got_nchar = 0;
        lnk.rx_got_time_code = 0; lnk.rx_error = 0; lnk.rx_disconnect = 0;
        lnk.credit_error = 0;

        // Reset values
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(posedge pclk); #1;
        reset = 1'b0;

        // Free run: ErrWait at edge 64, Ready at edge 192
        tick(63);  chk_all("errrst_63", 0, 0, 0, 0, 0);
        tick(1);   chk_all("errwait_64", 1, 1, 0, 0, 0);
        tick(127); chk_all("errwait_191", 1, 1, 0, 0, 0);
        tick(1);   chk_all("ready_192", 2, 1, 0, 0, 0);

        // Started with no NULL times out after exactly 128 cycles
        lnk.link_start = 1;
        tick(1);   chk_all("started", 3, 1, 1, 0, 0);
        tick(127); chk_all("started_127", 3, 1, 1, 0, 0);
        tick(1);   chk_all("started_tmo", 0, 0, 0, 0, 1);

        // Full bring-up to Run with NULL at +10 and FCT at +20
        tick(64);  chk_all("errwait_b", 1, 1, 0, 0, 1);
        tick(128); chk_all("ready_b", 2, 1, 0, 0, 1);
        tick(1);   chk_all("started_b", 3, 1, 1, 0, 1);
        tick(9);   chk_all("started_b9", 3, 1, 1, 0, 1);
        lnk.rx_got_null = 1; tick(1); lnk.rx_got_null = 0;
        chk_all("connecting_b", 4, 1, 2, 0, 1);
        tick(19);  chk_all("connecting_b19", 4, 1, 2, 0, 1);
        lnk.rx_got_fct = 1; tick(1); lnk.rx_got_fct = 0;
        chk_all("run_b", 5, 1, 3, 1, 1);

        // rx_error together with FCT in Run: error wins
        lnk.rx_error = 1; lnk.rx_got_fct = 1; tick(1);
        lnk.rx_error = 0; lnk.rx_got_fct = 0;
        chk_all("run_err", 0, 0, 0, 0, 2);

        // Auto-start: NULL seen in ErrWait starts the link on the first Ready cycle
        lnk.link_start = 0; lnk.auto_start = 1;
        tick(64);  chk_all("errwait_c", 1, 1, 0, 0, 2);
        tick(10);
        lnk.rx_got_null = 1; tick(1); lnk.rx_got_null = 0;
        chk_all("errwait_null", 1, 1, 0, 0, 2);
        tick(116); chk_all("errwait_c127", 1, 1, 0, 0, 2);
        tick(1);   chk_all("ready_c", 2, 1, 0, 0, 2);
        tick(1);   chk_all("started_c", 3, 1, 1, 0, 2);
        tick(1);   chk_all("connecting_c", 4, 1, 2, 0, 2);

        // link_disable is ignored in Connecting, but drops Run
        lnk.link_disable = 1;
        tick(5);   chk_all("conn_disable", 4, 1, 2, 0, 2);
        lnk.link_disable = 0;
        lnk.rx_got_fct = 1; tick(1); lnk.rx_got_fct = 0;
        chk_all("run_c", 5, 1, 3, 1, 2);
        lnk.credit_error = 1; tick(1); lnk.credit_error = 0;
        chk_all("run_credit", 0, 0, 0, 0, 3);

        // Asynchronous reset while Connecting
        lnk.link_start = 1;
        tick(64);  chk_all("errwait_d", 1, 1, 0, 0, 3);
        tick(128); chk_all("ready_d", 2, 1, 0, 0, 3);
        tick(1);   chk_all("started_d", 3, 1, 1, 0, 3);
        lnk.rx_got_null = 1; tick(1); lnk.rx_got_null = 0;
        chk_all("connecting_d", 4, 1, 2, 0, 3);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(posedge pclk); #1;
        reset = 1'b0;
        tick(63);  chk_all("rst_hold_63", 0, 0, 0, 0, 0);
        tick(1);   chk_all("rst_hold_64", 1, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
